// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush controller for the IF/ID and ID/EX pipeline registers.
// Compares ID source registers against in-flight destinations, tracks the
// multi-cycle MULT/DIV unit, and keeps saturating stall/flush counters.
// Build option: define FORWARDING_EN when the datapath has EX/MEM forwarding,
// which reduces data hazards to load-use only.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | previous cycle advanced normally
// DATA_ST | previous cycle held IF/ID for a register dependency
// MD_ST   | previous cycle held IF/ID waiting on HI/LO
// FLUSH   | previous cycle squashed the wrong-path instruction
module hazard_unit #(
   parameter int MD_CYCLES = 32,
   parameter int CNT_W     = 6,
   parameter int PERF_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              id_md_use,
   input  logic [4:0]        ex_dest,
   input  logic              ex_reg_write,
   input  logic              ex_mem_read,
   input  logic              ex_md_start,
   input  logic [4:0]        mem_dest,
   input  logic              mem_reg_write,
   input  logic              ex_branch_taken,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic              md_busy,
   output logic [1:0]        state,
   output logic [PERF_W-1:0] stall_count,
   output logic [PERF_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      ST_RUN        = 2'b00,
      ST_DATA_STALL = 2'b01,
      ST_MD_STALL   = 2'b10,
      ST_FLUSH      = 2'b11
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    md_cnt_q, md_cnt_d;
   logic [PERF_W-1:0]   stall_count_q, stall_count_d;
   logic [PERF_W-1:0]   flush_count_q, flush_count_d;

   logic ex_match;
   logic data_haz;
   logic md_haz;

   // $0 is hardwired to zero, so it never creates a dependency.
   assign ex_match = (ex_dest != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_dest)) || (id_uses_rt && (id_rt == ex_dest)));

`ifdef FORWARDING_EN
   // Forwarding covers ALU results; only a load in EX cannot be bypassed in time.
   logic unused_mem_inputs;
   assign unused_mem_inputs = ^{mem_dest, mem_reg_write};
   assign data_haz = ex_mem_read && ex_reg_write && ex_match;
`else
   // Without forwarding, wait until the producer has left MEM; WB writes in the
   // first half-cycle so the register file read already sees it.
   logic mem_match;
   logic unused_mem_read;
   assign unused_mem_read = ex_mem_read;
   assign mem_match = (mem_dest != 5'd0) &&
                      ((id_uses_rs && (id_rs == mem_dest)) || (id_uses_rt && (id_rt == mem_dest)));
   assign data_haz = (ex_reg_write && ex_match) || (mem_reg_write && mem_match);
`endif

   assign md_busy = (md_cnt_q != '0);
   assign md_haz  = id_md_use && md_busy;

   // Pipeline controls and next-state decision; branch flush outranks any stall.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      state_d     = ST_RUN;
      if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         state_d     = ST_FLUSH;
      end else if (data_haz) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         state_d     = ST_DATA_STALL;
      end else if (md_haz) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         state_d     = ST_MD_STALL;
      end
   end

   // MULT/DIV countdown (restart beats decrement) and saturating perf counters.
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (ex_md_start)
         md_cnt_d = CNT_W'(MD_CYCLES - 1);
      else if (md_cnt_q != '0)
         md_cnt_d = md_cnt_q - CNT_W'(1);

      stall_count_d = stall_count_q;
      if (!pc_write && (stall_count_q != '1))
         stall_count_d = stall_count_q + PERF_W'(1);

      flush_count_d = flush_count_q;
      if (ifid_flush && (flush_count_q != '1))
         flush_count_d = flush_count_q + PERF_W'(1);
   end

   // State record, countdown and counters; reset drops any pending MD stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_RUN;
         md_cnt_q      <= '0;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         state_q       <= state_d;
         md_cnt_q      <= md_cnt_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign state       = state_q;
   assign stall_count = stall_count_q;
   assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit: directed scenarios followed by random traffic,
// checked against a cycle-indexed behavioural model. A second instance with a
// short MULT/DIV latency and 4-bit counters exercises counter saturation.
module tb_hazard_unit;

   localparam int MDC   = 32;
   localparam int MDC_S = 5;
   localparam longint MAX_M = 64'hFFFF_FFFF;
   localparam longint MAX_S = 15;

   logic clk, rst;
   logic [4:0] id_rs, id_rt, ex_dest, mem_dest;
   logic id_uses_rs, id_uses_rt, id_md_use, ex_reg_write, ex_mem_read, ex_md_start;
   logic mem_reg_write, ex_branch_taken;

   logic pc_write, ifid_write, ifid_flush, idex_bubble, md_busy;
   logic [1:0] state;
   logic [31:0] stall_count, flush_count;

   logic pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s, md_busy_s;
   logic [1:0] state_s;
   logic [3:0] stall_count_s, flush_count_s;

   hazard_unit dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_md_use(id_md_use),
      .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_md_start(ex_md_start), .mem_dest(mem_dest), .mem_reg_write(mem_reg_write),
      .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .md_busy(md_busy),
      .state(state), .stall_count(stall_count), .flush_count(flush_count)
   );

   hazard_unit #(.MD_CYCLES(MDC_S), .CNT_W(3), .PERF_W(4)) dut_s (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_md_use(id_md_use),
      .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_md_start(ex_md_start), .mem_dest(mem_dest), .mem_reg_write(mem_reg_write),
      .ex_branch_taken(ex_branch_taken), .pc_write(pc_write_s), .ifid_write(ifid_write_s),
      .ifid_flush(ifid_flush_s), .idex_bubble(idex_bubble_s), .md_busy(md_busy_s),
      .state(state_s), .stall_count(stall_count_s), .flush_count(flush_count_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // Model: time-indexed view of the MULT/DIV unit and plain saturating tallies.
   int cyc = 0;
   int md_start = -100000;
   int st_m = 0, st_s = 0;
   longint stall_m = 0, flush_m = 0, stall_s = 0, flush_s = 0;
   bit m_pcw, m_fl, s_pcw, s_fl;
   int m_nst, s_nst;
   logic obs_pcw, obs_fl, obs_bub, obs_busy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic bit md_is_busy(input int lat);
      int d;
      d = cyc - md_start;
      return (d >= 1) && (d <= lat - 1);
   endfunction

   function automatic bit reads(input logic [4:0] d);
      return (d != 5'd0) && ((id_uses_rs && id_rs == d) || (id_uses_rt && id_rt == d));
   endfunction

   function automatic bit dep_hazard();
`ifdef FORWARDING_EN
      return ex_mem_read && ex_reg_write && reads(ex_dest);
`else
      return (ex_reg_write && reads(ex_dest)) || (mem_reg_write && reads(mem_dest));
`endif
   endfunction

   task automatic decide(input bit busy, output bit pcw, output bit ifw, output bit fl,
                         output bit bub, output int nst);
      if (ex_branch_taken) begin pcw = 1; ifw = 1; fl = 1; bub = 1; nst = 3; end
      else if (dep_hazard()) begin pcw = 0; ifw = 0; fl = 0; bub = 1; nst = 1; end
      else if (id_md_use && busy) begin pcw = 0; ifw = 0; fl = 0; bub = 1; nst = 2; end
      else begin pcw = 1; ifw = 1; fl = 0; bub = 0; nst = 0; end
   endtask

   task automatic check_now();
      bit ifw, bub, ifw_s, bub_s;
      decide(md_is_busy(MDC), m_pcw, ifw, m_fl, bub, m_nst);
      decide(md_is_busy(MDC_S), s_pcw, ifw_s, s_fl, bub_s, s_nst);
      chk("pc_write", pc_write, m_pcw);
      chk("ifid_write", ifid_write, ifw);
      chk("ifid_flush", ifid_flush, m_fl);
      chk("idex_bubble", idex_bubble, bub);
      chk("md_busy", md_busy, md_is_busy(MDC));
      chk("state", state, st_m);
      chk("stall_count", stall_count, stall_m);
      chk("flush_count", flush_count, flush_m);
      chk("s_pc_write", pc_write_s, s_pcw);
      chk("s_idex_bubble", idex_bubble_s, bub_s);
      chk("s_md_busy", md_busy_s, md_is_busy(MDC_S));
      chk("s_state", state_s, st_s);
      chk("s_stall_count", stall_count_s, stall_s);
      chk("s_flush_count", flush_count_s, flush_s);
      obs_pcw = pc_write; obs_fl = ifid_flush; obs_bub = idex_bubble; obs_busy = md_busy;
   endtask

   // Called just after a falling edge with the cycle's inputs already driven.
   task automatic run_cycle();
      #1;
      check_now();
      @(posedge clk);
      if (!rst) begin
         if (!m_pcw && stall_m < MAX_M) stall_m++;
         if (m_fl && flush_m < MAX_M) flush_m++;
         if (!s_pcw && stall_s < MAX_S) stall_s++;
         if (s_fl && flush_s < MAX_S) flush_s++;
         st_m = m_nst;
         st_s = s_nst;
         if (ex_md_start) md_start = cyc;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      md_start = -100000;
      st_m = 0; st_s = 0;
      stall_m = 0; flush_m = 0; stall_s = 0; flush_s = 0;
      check_now();
      repeat (2) begin @(posedge clk); cyc++; end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic quiet();
      id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_md_use = 0;
      ex_dest = 0; ex_reg_write = 0; ex_mem_read = 0; ex_md_start = 0;
      mem_dest = 0; mem_reg_write = 0; ex_branch_taken = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      quiet();
      @(negedge clk);
      apply_reset();
      chk("reset_pc_write", pc_write, 1);

      // ALU producer of $9 followed by a reader of $9.
      ex_dest = 9; ex_reg_write = 1; id_rs = 9; id_uses_rs = 1;
      run_cycle();
      ex_dest = 0; ex_reg_write = 0; mem_dest = 9; mem_reg_write = 1;
      run_cycle();
      mem_dest = 0; mem_reg_write = 0;
      run_cycle();
`ifdef FORWARDING_EN
      chk("alu_dep_stalls", stall_count, 0);
`else
      chk("alu_dep_stalls", stall_count, 2);
`endif

      // Writes to $0 never create a dependency.
      quiet();
      ex_dest = 0; ex_reg_write = 1; ex_mem_read = 1; mem_dest = 0; mem_reg_write = 1;
      id_rs = 0; id_uses_rs = 1; id_rt = 0; id_uses_rt = 1;
      run_cycle();
      chk("zero_reg_no_stall", obs_pcw, 1);

      // Load-use on $8.
      quiet();
      apply_reset();
      ex_mem_read = 1; ex_reg_write = 1; ex_dest = 8; id_rs = 8; id_uses_rs = 1;
      run_cycle();
      chk("load_use_bubble", obs_bub, 1);
      ex_mem_read = 0; ex_reg_write = 0; ex_dest = 0; mem_dest = 8; mem_reg_write = 1;
      run_cycle();
      quiet();
      run_cycle();
`ifdef FORWARDING_EN
      chk("load_use_stalls", stall_count, 1);
`else
      chk("load_use_stalls", stall_count, 2);
`endif

      // MULT/DIV then MFLO: stalls until the countdown drains.
      apply_reset();
      ex_md_start = 1;
      run_cycle();
      ex_md_start = 0; id_md_use = 1;
      n = 0;
      obs_pcw = 0;
      for (int i = 0; i < 100; i++) begin
         run_cycle();
         if (obs_pcw) break;
         n++;
      end
      chk("md_stall_cycles", n, MDC - 1);
      quiet();
      run_cycle();

      // Branch in the middle of an MD stall, then reset at md_cnt == 20.
      apply_reset();
      ex_md_start = 1;
      run_cycle();
      ex_md_start = 0; id_md_use = 1;
      repeat (4) run_cycle();
      ex_branch_taken = 1;
      run_cycle();
      chk("branch_flush", obs_fl, 1);
      chk("branch_pc_write", obs_pcw, 1);
      ex_branch_taken = 0;
      repeat (6) run_cycle();
      chk("branch_flush_count", flush_count, 1);
      chk("md_still_busy", md_busy, 1);
      apply_reset();
      chk("reset_mid_md_busy", md_busy, 0);
      chk("reset_mid_md_pcw", pc_write, 1);
      chk("reset_mid_md_stall_cnt", stall_count, 0);
      quiet();

      // Held load-use hazard for 20 cycles: 4-bit counter pins at 15.
      ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5; id_rt = 5; id_uses_rt = 1;
      repeat (20) run_cycle();
      chk("sat_small_stall", stall_count_s, 15);
      chk("sat_main_stall", stall_count, 20);
      quiet();
      run_cycle();

      // Random traffic with small register numbers to provoke dependencies.
      for (int i = 0; i < 600; i++) begin
         id_rs = 5'($urandom_range(0, 3));
         id_rt = 5'($urandom_range(0, 3));
         ex_dest = 5'($urandom_range(0, 3));
         mem_dest = 5'($urandom_range(0, 3));
         id_uses_rs = 1'($urandom);
         id_uses_rt = 1'($urandom);
         ex_reg_write = 1'($urandom);
         ex_mem_read = 1'($urandom);
         mem_reg_write = 1'($urandom);
         id_md_use = 1'($urandom);
         ex_md_start = ($urandom_range(0, 15) == 0);
         ex_branch_taken = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 99) == 0) apply_reset();
         else run_cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
